// File: rtl/secded_pkg.sv
// Shared constants, code layout and classification type for the SECDED(32,26) check path.
package secded_pkg;

    localparam int CODE_W = 32;
    localparam int DATA_W = 26;
    localparam int SYND_W = 5;

    // Code-bit index (Hamming position - 1) that carries each data bit, data[0] first.
    localparam logic [4:0] DATA_POS [DATA_W] = '{
        5'd2,  5'd4,  5'd5,  5'd6,  5'd8,  5'd9,  5'd10, 5'd11, 5'd12,
        5'd13, 5'd14, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22,
        5'd23, 5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30
    };

    typedef enum logic [1:0] {CLEAN, CE, UE} secded_class_e;

    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < DATA_W; i++) begin
            d[i] = code[DATA_POS[i]];
        end
        return d;
    endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Hamming syndrome and overall parity of a 32-bit SECDED codeword.
// Purely combinational: zero latency, no flow control.
module secded_syndrome
    import secded_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SYND_W-1:0] syndrome,
    output logic              parity
);

    always_comb begin
        syndrome = '0;
        for (int i = 0; i < CODE_W - 1; i++) begin
            if (code[i]) begin
                syndrome = syndrome ^ SYND_W'(i + 1);
            end
        end
        parity = ^code;
    end

endmodule

// File: rtl/secded_check_pipe.sv
// SECDED(32,26) decode/correct in a 2-stage valid/ready pipe (2-cycle latency, 1 word/cycle), stalls hold payload.
// Saturating CE/UE statistics; sticky UE flag only when SECDED_STICKY_UE_EN is defined.
module secded_check_pipe
    import secded_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CODE_W-1:0]   in_code,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_ce,
    output logic                out_ue,
    output logic [SYND_W-1:0]   out_syndrome,
    input  logic                clr_counts,
    output logic [CNT_W-1:0]    ce_count,
    output logic [CNT_W-1:0]    ue_count,
    output logic [4:0]          last_ce_idx,
    output logic                ue_sticky
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYND_W-1:0] in_syn;
    logic              in_par;

    secded_syndrome u_syndrome (
        .code     (in_code),
        .syndrome (in_syn),
        .parity   (in_par)
    );

    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic [SYND_W-1:0] s1_syn;
    logic              s1_par;
    logic              s2_adv;
    logic              out_hs;
    logic [4:0]        s2_idx;

    assign s2_adv   = !out_valid || out_ready;
    // Held low during reset so nothing is accepted into a pipe that is being flushed.
    assign in_ready = rst_n && (!s1_valid || s2_adv);
    assign out_hs   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= in_code;
                s1_syn  <= in_syn;
                s1_par  <= in_par;
            end
        end
    end

    secded_class_e     cls;
    logic [CODE_W-1:0] fixed;
    logic [4:0]        ce_idx;

    // Odd overall parity means a single flip; syndrome 0 then points at the parity bit itself.
    always_comb begin
        cls    = CLEAN;
        fixed  = s1_code;
        ce_idx = 5'd31;
        if (s1_par) begin
            cls = CE;
            if (s1_syn != '0) begin
                ce_idx = s1_syn - 5'd1;
                fixed  = s1_code ^ (CODE_W'(1) << ce_idx);
            end
        end else if (s1_syn != '0) begin
            cls = UE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_ce       <= 1'b0;
            out_ue       <= 1'b0;
            out_syndrome <= '0;
            s2_idx       <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data     <= extract_data(fixed);
                out_ce       <= (cls == CE);
                out_ue       <= (cls == UE);
                out_syndrome <= s1_syn;
                s2_idx       <= ce_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_count    <= '0;
            ue_count    <= '0;
            last_ce_idx <= '0;
        end else if (clr_counts) begin
            ce_count    <= '0;
            ue_count    <= '0;
            last_ce_idx <= '0;
        end else if (out_hs) begin
            if (out_ce) begin
                if (ce_count != CNT_MAX) begin
                    ce_count <= ce_count + 1'b1;
                end
                last_ce_idx <= s2_idx;
            end
            if (out_ue && (ue_count != CNT_MAX)) begin
                ue_count <= ue_count + 1'b1;
            end
        end
    end

`ifdef SECDED_STICKY_UE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ue_sticky <= 1'b0;
        end else if (clr_counts) begin
            ue_sticky <= 1'b0;
        end else if (out_hs && out_ue) begin
            ue_sticky <= 1'b1;
        end
    end
`else
    assign ue_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_secded_check_pipe.sv
// Bench for secded_check_pipe: fixed vectors, stall/clear/reset sequences and a randomized scoreboard run.
module tb_secded_check_pipe;

    localparam int  TB_CNT_W = 2;
    localparam int  CMAX     = 3;
`ifdef SECDED_STICKY_UE_EN
    localparam bit  STICKY_EN = 1'b1;
`else
    localparam bit  STICKY_EN = 1'b0;
`endif

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_code;
    logic                out_valid;
    logic                out_ready;
    logic [25:0]         out_data;
    logic                out_ce;
    logic                out_ue;
    logic [4:0]          out_syndrome;
    logic                clr_counts;
    logic [TB_CNT_W-1:0] ce_count;
    logic [TB_CNT_W-1:0] ue_count;
    logic [4:0]          last_ce_idx;
    logic                ue_sticky;

    secded_check_pipe #(.CNT_W(TB_CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_code      (in_code),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_ce       (out_ce),
        .out_ue       (out_ue),
        .out_syndrome (out_syndrome),
        .clr_counts   (clr_counts),
        .ce_count     (ce_count),
        .ue_count     (ue_count),
        .last_ce_idx  (last_ce_idx),
        .ue_sticky    (ue_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [25:0] data;
        logic        ce;
        logic        ue;
        logic [4:0]  syn;
        logic [4:0]  idx;
        int          t;
    } exp_t;

    typedef struct {
        logic [31:0] code;
        logic [25:0] data;
        logic        ce;
        logic        ue;
        logic [4:0]  syn;
        logic [4:0]  idx;
        logic [1:0]  cec;
        logic [1:0]  uec;
    } vec_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    exp_t q[$];
    int   m_ce, m_ue, m_idx;
    bit   m_stk;
    bit   acc;
    bit   stall_prev;
    logic [25:0] prev_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the code rules, walking Hamming positions.
    function automatic exp_t ref_decode(input logic [31:0] c_in);
        exp_t e;
        logic [31:0] c;
        int s, p, k;
        c = c_in; s = 0; p = 0; k = 0;
        for (int i = 0; i < 31; i++) if (c[i]) s = s ^ (i + 1);
        for (int i = 0; i < 32; i++) p = p ^ int'(c[i]);
        e.ce = 1'b0; e.ue = 1'b0; e.idx = 5'd0; e.syn = 5'(s); e.t = 0;
        if (p == 1) begin
            e.ce = 1'b1;
            if (s != 0) begin
                c[s-1] = ~c[s-1];
                e.idx = 5'(s - 1);
            end else begin
                e.idx = 5'd31;
            end
        end else if (s != 0) begin
            e.ue = 1'b1;
        end
        e.data = '0;
        for (int pos = 1; pos <= 31; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                e.data[k] = c[pos-1];
                k++;
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] encode(input logic [25:0] d);
        logic [31:0] c;
        int k;
        logic par;
        c = '0; k = 0;
        for (int pos = 1; pos <= 31; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[k];
                k++;
            end
        end
        for (int j = 0; j < 5; j++) begin
            par = 1'b0;
            for (int pos = 1; pos <= 31; pos++) if ((pos & (1 << j)) != 0) par = par ^ c[pos-1];
            c[(1 << j) - 1] = par;
        end
        c[31] = ^c[30:0];
        return c;
    endfunction

    function automatic logic [31:0] corrupt(input logic [31:0] c, input int nflip);
        logic [31:0] r;
        int b1, b2;
        r  = c;
        b1 = $urandom_range(0, 31);
        b2 = (b1 + 1 + $urandom_range(0, 30)) % 32;
        if (nflip >= 1) r[b1] = ~r[b1];
        if (nflip >= 2) r[b2] = ~r[b2];
        return r;
    endfunction

    // One clock cycle, entered and left at posedge+1; checks at the negedge and after the edge.
    task automatic step(input logic iv, input logic [31:0] code, input logic ordy, input logic clr);
        exp_t e;
        in_valid = iv; in_code = code; out_ready = ordy; clr_counts = clr;
        acc = 1'b0;
        @(negedge clk);
        chk("in_ready", in_ready, ((q.size() < 2) || ordy) ? 1 : 0);
        chk("out_valid", out_valid, ((q.size() > 0) && (cyc - q[0].t >= 1)) ? 1 : 0);
        if (stall_prev) chk("hold_data", out_data, prev_data);
        stall_prev = out_valid && !ordy;
        prev_data  = out_data;
        if (out_valid && ordy && (q.size() > 0)) begin
            e = q.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_ce", out_ce, e.ce);
            chk("out_ue", out_ue, e.ue);
            chk("out_syndrome", out_syndrome, e.syn);
            if (!clr) begin
                if (e.ce) begin
                    if (m_ce < CMAX) m_ce++;
                    m_idx = e.idx;
                end
                if (e.ue) begin
                    if (m_ue < CMAX) m_ue++;
                    m_stk = 1'b1;
                end
            end
        end
        if (clr) begin
            m_ce = 0; m_ue = 0; m_idx = 0; m_stk = 1'b0;
        end
        if (iv && in_ready) begin
            e = ref_decode(code);
            e.t = cyc + 1;
            q.push_back(e);
            acc = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("ce_count", ce_count, m_ce);
        chk("ue_count", ue_count, m_ue);
        chk("last_ce_idx", last_ce_idx, m_idx);
        chk("ue_sticky", ue_sticky, (STICKY_EN && m_stk) ? 1 : 0);
    endtask

    vec_t        tv[8];
    logic [31:0] w[4];
    int          widx;
    logic [31:0] rc;

    initial begin
        tv[0] = '{32'h80000007, 26'h1, 1'b0, 1'b0, 5'd0, 5'd0,  2'd0, 2'd0};
        tv[1] = '{32'h80000003, 26'h1, 1'b1, 1'b0, 5'd3, 5'd2,  2'd1, 2'd0};
        tv[2] = '{32'h80000004, 26'h1, 1'b0, 1'b1, 5'd3, 5'd2,  2'd1, 2'd1};
        tv[3] = '{32'h00000007, 26'h1, 1'b1, 1'b0, 5'd0, 5'd31, 2'd2, 2'd1};
        tv[4] = '{32'h00000000, 26'h0, 1'b0, 1'b0, 5'd0, 5'd31, 2'd2, 2'd1};
        tv[5] = '{32'h00000001, 26'h0, 1'b1, 1'b0, 5'd1, 5'd0,  2'd3, 2'd1};
        tv[6] = '{32'h80000000, 26'h0, 1'b1, 1'b0, 5'd0, 5'd31, 2'd3, 2'd1};
        tv[7] = '{32'h00000003, 26'h0, 1'b0, 1'b1, 5'd3, 5'd31, 2'd3, 2'd2};
        m_ce = 0; m_ue = 0; m_idx = 0; m_stk = 1'b0; stall_prev = 1'b0; prev_data = '0;

        rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b0; clr_counts = 1'b0;
        #3;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_ce_count", ce_count, 0);
        chk("rst_ue_count", ue_count, 0);
        chk("rst_sticky", ue_sticky, 0);
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_code = tv[i].code; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0; in_code = '0;
            @(posedge clk); #1;
            chk("tbl_valid", out_valid, 1);
            chk("tbl_data", out_data, tv[i].data);
            chk("tbl_ce", out_ce, tv[i].ce);
            chk("tbl_ue", out_ue, tv[i].ue);
            chk("tbl_syndrome", out_syndrome, tv[i].syn);
            @(posedge clk); #1;
            chk("tbl_drained", out_valid, 0);
            chk("tbl_ce_count", ce_count, tv[i].cec);
            chk("tbl_ue_count", ue_count, tv[i].uec);
            chk("tbl_last_idx", last_ce_idx, tv[i].idx);
            chk("tbl_sticky", ue_sticky, (STICKY_EN && (tv[i].uec != 0)) ? 1 : 0);
        end
        step(1'b0, '0, 1'b1, 1'b1);

        // Stream of four words with out_ready low for three cycles mid-stream.
        for (int i = 0; i < 4; i++) w[i] = corrupt(encode(26'($urandom)), i % 3);
        widx = 0;
        for (int c = 0; c < 20; c++) begin
            step(widx < 4, (widx < 4) ? w[widx] : 32'h0, !(c >= 2 && c <= 4), 1'b0);
            if (acc) widx++;
        end
        chk("stream_all_sent", widx, 4);
        chk("stream_drained", q.size(), 0);

        // Four CE words into a 2-bit counter, then a clear on the same cycle as a CE handshake.
        for (int i = 0; i < 4; i++) step(1'b1, corrupt(encode(26'($urandom)), 1), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("ce_saturated", ce_count, 3);
        step(1'b1, encode(26'h155) ^ 32'h00000100, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("clr_wins_ce", ce_count, 0);
        chk("clr_wins_idx", last_ce_idx, 0);

        // Randomized traffic against the scoreboard.
        for (int c = 0; c < 400; c++) begin
            rc = corrupt(encode(26'($urandom)), $urandom_range(0, 2));
            step(($urandom % 4) != 0, rc, ($urandom % 4) != 0, ($urandom % 32) == 0);
        end
        for (int c = 0; c < 4; c++) step(1'b0, '0, 1'b1, 1'b0);
        chk("random_drained", q.size(), 0);

        // Reset asserted while the pipe is full and counters are non-zero.
        step(1'b1, encode(26'h3) ^ 32'h4, 1'b1, 1'b0);
        step(1'b1, encode(26'h5) ^ 32'h3, 1'b1, 1'b0);
        step(1'b1, encode(26'h7), 1'b0, 1'b0);
        step(1'b1, encode(26'h9), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_ce_count", ce_count, 0);
        chk("midrst_ue_count", ue_count, 0);
        chk("midrst_sticky", ue_sticky, 0);
        q.delete();
        m_ce = 0; m_ue = 0; m_idx = 0; m_stk = 1'b0; stall_prev = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, encode(26'h2AAAAAA) ^ 32'h80000000, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b1, 1'b0);
        chk("post_rst_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/secded_check_pipe.md
Name: secded_check_pipe

Overview:
- Consumes the 32-bit encoded word produced by the error-injection stage.
- Decodes it as SECDED(32,26), corrects single-bit errors and flags double-bit errors.
- Emits 26-bit data through a 2-stage valid/ready pipeline toward the TMR voter.
- Keeps saturating CE/UE counters and the index of the last corrected bit for fault-campaign reporting.

Parameters:
- CNT_W, 16, width of the correctable/uncorrectable event counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  codeword valid
- in_ready  out  1  stage-1 can accept
- in_code  in  32  encoded word (possibly corrupted)
- out_valid  out  1  decoded result valid
- out_ready  in  1  consumer accepts
- out_data  out  26  corrected data
- out_ce  out  1  single error corrected
- out_ue  out  1  uncorrectable (double) error
- out_syndrome  out  5  Hamming syndrome of this word
- clr_counts  in  1  synchronous clear of statistics
- ce_count  out  CNT_W  corrected-error count
- ue_count  out  CNT_W  uncorrectable-error count
- last_ce_idx  out  5  bit index last corrected
- ue_sticky  out  1  sticky UE flag (see Optional Feature)

Behaviour:
- Code layout:
  - bit i (0..30) is Hamming position i+1.
  - Parity at positions 1,2,4,8,16.
  - Data bits fill the remaining positions ascending (data[0] at position 3).
  - bit 31 = overall even parity over bits 30:0.
- Stage 1 registers in_code, syndrome s (XOR of positions of set bits 0..30) and p (XOR of all 32 bits). Stage 2 registers the corrected result.
- Classification:
  - s==0,p==0: clean.
  - p==1,s!=0: flip bit s-1, ce=1, idx=s-1.
  - p==1,s==0: bit 31 in error, data unchanged, ce=1, idx=31.
  - s!=0,p==0: ue=1, data extracted uncorrected.
  - ce and ue are never both 1.
- Latency: 2 cycles from in handshake to out_valid when unstalled. Full throughput: 1 word/cycle.
- Handshake:
  - Each stage loads when empty or when its contents leave that cycle.
  - in_ready = !s1_valid | (s2 empty | out_ready). No combinational path from in_valid to out_valid.
  - Output payload holds stable while out_valid & !out_ready.
- Counters:
  - Update only on an output handshake: ce_count+=1 on ce, ue_count+=1 on ue.
  - Saturate at 2^CNT_W-1.
  - last_ce_idx updates on a ce handshake.
- clr_counts zeroes both counters, last_ce_idx and ue_sticky. A same-cycle increment is discarded (clear wins).
- Reset (async, any time, including mid-transfer): all valids 0, in_ready 0 while rst_n low, out_* 0, counters 0, last_ce_idx 0, ue_sticky 0. In-flight words are dropped.

Optional Feature:
- Macro SECDED_STICKY_UE_EN.
- Defined: ue_sticky sets on the first ue handshake and holds until clr_counts or reset.
- Undefined: ue_sticky is constant 0 and no flop is inferred.
- All other behaviour is identical.

Decomposition:
- Package secded_pkg holds:
  - CODE_W=32, DATA_W=26, SYND_W=5.
  - Data-position constant array.
  - Class enum {CLEAN, CE, UE}.
- One combinational sub-module, secded_syndrome (in_code -> s, p), shared with the future encoder check.

Test Plan:
- in_code 32'h80000007 (data 26'h1), out_ready=1 -> after 2 cycles out_data 26'h1, ce=0, ue=0, syndrome 0.
- in_code 32'h80000003 (bit 2 flipped) -> out_data 26'h1, ce=1, syndrome 3, last_ce_idx 2, ce_count 1.
- in_code 32'h80000004 (bits 0,1 flipped) -> ue=1, syndrome 3, ue_count 1, ue_sticky 1 only with SECDED_STICKY_UE_EN.
- in_code 32'h00000007 (bit 31 flipped) -> out_data 26'h1, ce=1, last_ce_idx 31.
- Stream 4 words, out_ready low for 3 cycles mid-stream -> no loss or duplication, payload stable, in_ready drops when both stages are full.
- Preload ce_count to max via CNT_W=2 with 4 CE words -> sticks at 3. clr_counts coincident with a CE handshake -> 0. rst_n low mid-stream -> out_valid 0 immediately.
